// File: rtl/input_scanner.sv
// Scans a 74HC165 PISO chain (PL_n / SCK / CE_n) and presents the captured word with a one-cycle strobe.
// Optional macro SCANNER_DEBOUNCE_EN: only publish a scan that matches the previous completed scan.
module input_scanner #(
  parameter int NUM_BITS    = 16,
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                START,
  input  logic                SER_IN,
  output logic                PL_n,
  output logic                SCK,
  output logic                CE_n,
  output logic [NUM_BITS-1:0] BTN_DATA,
  output logic                DATA_VALID,
  output logic                BUSY
);

  localparam int MAX_DIV = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DIV + 1);
  localparam int BIT_W   = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_HI,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [NUM_BITS-2:0] capture;
  logic [NUM_BITS-1:0] scan_word;

`ifdef SCANNER_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prev_scan;
`endif

  // capture holds the first NUM_BITS-1 samples; the last sample joins straight from SER_IN
  assign scan_word = {capture, SER_IN};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      PL_n       <= 1'b1;
      SCK        <= 1'b0;
      CE_n       <= 1'b1;
      BUSY       <= 1'b0;
      DATA_VALID <= 1'b0;
      BTN_DATA   <= '0;
      capture    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
`ifdef SCANNER_DEBOUNCE_EN
      prev_scan  <= '0;
`endif
    end else begin
      DATA_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state   <= LOAD;
            PL_n    <= 1'b0;
            BUSY    <= 1'b1;
            capture <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end

        LOAD: begin
          if (div_cnt == LOAD_LAST) begin
            state   <= SETTLE;
            PL_n    <= 1'b1;
            CE_n    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        SETTLE: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
              CE_n  <= 1'b1;
              // BTN_DATA is written on entry to DONE so it is already valid while the strobe is high
`ifdef SCANNER_DEBOUNCE_EN
              if (scan_word == prev_scan) begin
                BTN_DATA   <= scan_word;
                DATA_VALID <= 1'b1;
              end
              prev_scan <= scan_word;
`else
              BTN_DATA   <= scan_word;
              DATA_VALID <= 1'b1;
`endif
            end else begin
              capture <= scan_word[NUM_BITS-2:0];
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= SHIFT_HI;
              SCK     <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            state   <= SETTLE;
            SCK     <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_scanner.sv
// Bench for input_scanner: behavioural 74HC165 chains feed two scanner instances; a queue-based
// scoreboard checks every DATA_VALID against expected word, latency and SCK edge count.
module tb_input_scanner;

  typedef struct {
    logic [15:0] data;
    int          k;
    int          lat;
    int          sck;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Instance A: default geometry, two chained devices
  logic        start_a = 1'b0;
  logic        ser_a, pl_n_a, sck_a, ce_n_a, dv_a, busy_a;
  logic [15:0] btn_a;
  logic [15:0] par_a = '0;
  logic [15:0] sr_a = '0;

  // Instance B: single device, fastest timing
  logic        start_b = 1'b0;
  logic        ser_b, pl_n_b, sck_b, ce_n_b, dv_b, busy_b;
  logic [7:0]  btn_b;
  logic [7:0]  par_b = '0;
  logic [7:0]  sr_b = '0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a, e_b;
  int   sck_cnt_a = 0, sck_cnt_b = 0;
  logic sck_prev_a = 1'b0, sck_prev_b = 1'b0;

  input_scanner #(.NUM_BITS(16), .CLK_DIV(4), .LOAD_CYCLES(2)) dut_a (
    .CLK(clk), .RST_n(rst_n), .START(start_a), .SER_IN(ser_a),
    .PL_n(pl_n_a), .SCK(sck_a), .CE_n(ce_n_a),
    .BTN_DATA(btn_a), .DATA_VALID(dv_a), .BUSY(busy_a)
  );

  input_scanner #(.NUM_BITS(8), .CLK_DIV(1), .LOAD_CYCLES(1)) dut_b (
    .CLK(clk), .RST_n(rst_n), .START(start_b), .SER_IN(ser_b),
    .PL_n(pl_n_b), .SCK(sck_b), .CE_n(ce_n_b),
    .BTN_DATA(btn_b), .DATA_VALID(dv_b), .BUSY(busy_b)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 74HC165 chain: async parallel load while PL_n low, shift on SCK rise while CE_n low, DS tied low
  always @(negedge pl_n_a or posedge sck_a)
    if (!pl_n_a) sr_a <= par_a;
    else if (!ce_n_a) sr_a <= {sr_a[14:0], 1'b0};
  assign ser_a = sr_a[15];

  always @(negedge pl_n_b or posedge sck_b)
    if (!pl_n_b) sr_b <= par_b;
    else if (!ce_n_b) sr_b <= {sr_b[6:0], 1'b0};
  assign ser_b = sr_b[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The strobe shown after edge j is captured by downstream logic on edge j+1, hence the +1
  always @(negedge clk) begin
    if (!rst_n) begin
      sck_cnt_a = 0;
      sck_cnt_b = 0;
    end else begin
      if (sck_a && !sck_prev_a) sck_cnt_a++;
      if (sck_b && !sck_prev_b) sck_cnt_b++;
      if (dv_a) begin
        check("valid_a_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e_a = exp_a.pop_front();
          check("data_a", 32'(btn_a), 32'(e_a.data));
          check("latency_a", cyc - e_a.k + 1, e_a.lat);
          check("sck_edges_a", sck_cnt_a, e_a.sck);
        end
        sck_cnt_a = 0;
      end
      if (dv_b) begin
        check("valid_b_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e_b = exp_b.pop_front();
          check("data_b", 32'(btn_b), 32'(e_b.data));
          check("latency_b", cyc - e_b.k + 1, e_b.lat);
          check("sck_edges_b", sck_cnt_b, e_b.sck);
        end
        sck_cnt_b = 0;
      end
    end
    sck_prev_a = sck_a;
    sck_prev_b = sck_b;
  end

  task automatic pulse_start_a(input logic [15:0] d, input bit expect_dv, output int k);
    par_a = d;
    @(negedge clk);
    start_a = 1'b1;
    k = cyc + 1;
    if (expect_dv) exp_a.push_back('{data: d, k: k, lat: 127, sck: 15});
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b(input logic [7:0] d, input bit expect_dv, output int k);
    par_b = d;
    @(negedge clk);
    start_b = 1'b1;
    k = cyc + 1;
    if (expect_dv) exp_b.push_back('{data: {8'h00, d}, k: k, lat: 17, sck: 7});
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain_a(input int bound);
    for (int i = 0; i < bound && exp_a.size() != 0; i++) @(negedge clk);
    check("drain_a", exp_a.size(), 0);
  endtask

  task automatic wait_idle_a(input int bound);
    for (int i = 0; i < bound && busy_a; i++) @(negedge clk);
    check("idle_a", 32'(busy_a), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int busy_low;

    repeat (3) @(negedge clk);
    check("rst_pl_n", 32'(pl_n_a), 32'd1);
    check("rst_sck", 32'(sck_a), 32'd0);
    check("rst_ce_n", 32'(ce_n_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(dv_a), 32'd0);
    check("rst_btn", 32'(btn_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef SCANNER_DEBOUNCE_EN
    // Single scan with load-phase boundary checks
    pulse_start_a(16'hA53C, 1'b1, k);
    check("load_pl_n_first", 32'(pl_n_a), 32'd0);
    check("load_busy", 32'(busy_a), 32'd1);
    check("load_ce_n", 32'(ce_n_a), 32'd1);
    @(negedge clk);
    check("load_pl_n_last", 32'(pl_n_a), 32'd0);
    @(negedge clk);
    check("settle_pl_n", 32'(pl_n_a), 32'd1);
    check("settle_ce_n", 32'(ce_n_a), 32'd0);
    check("settle_sck", 32'(sck_a), 32'd0);
    drain_a(200);
    wait_idle_a(5);

    // START held high: three back-to-back scans 128 cycles apart
    par_a = 16'h5AF0;
    @(negedge clk);
    start_a = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) exp_a.push_back('{data: 16'h5AF0, k: k + 128 * i, lat: 127, sck: 15});
    drain_a(500);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b_stopped", 32'(busy_a), 32'd0);

    // Second START mid-scan is ignored and BUSY never drops
    pulse_start_a(16'h0F0F, 1'b1, k);
    busy_low = 0;
    while (cyc < k + 126) begin
      if (!busy_a) busy_low++;
      start_a = (cyc == k + 39);
      @(negedge clk);
    end
    start_a = 1'b0;
    check("busy_continuous", busy_low, 0);
    drain_a(10);
    repeat (140) @(negedge clk);
    check("no_second_scan", 32'(busy_a), 32'd0);

    // Reset mid-scan abandons everything
    pulse_start_a(16'h8001, 1'b1, k);
    while (cyc < k + 60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_pl_n", 32'(pl_n_a), 32'd1);
    check("abort_sck", 32'(sck_a), 32'd0);
    check("abort_ce_n", 32'(ce_n_a), 32'd1);
    check("abort_btn", 32'(btn_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    exp_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start_a(16'hC3A5, 1'b1, k);
    drain_a(200);
    wait_idle_a(5);

    // Small geometry: one-cycle load, one-cycle SCK half-periods
    pulse_start_b(8'h81, 1'b1, k);
    check("b_load_pl_n", 32'(pl_n_b), 32'd0);
    @(negedge clk);
    check("b_settle_pl_n", 32'(pl_n_b), 32'd1);
    for (int i = 0; i < 40 && exp_b.size() != 0; i++) @(negedge clk);
    check("drain_b", exp_b.size(), 0);
    check("b_btn_hold", 32'(btn_b), 32'h81);
`else
    // Debounce: a scan is published only when it matches the previous one
    pulse_start_a(16'h1234, 1'b0, k);
    wait_idle_a(200);
    check("deb_first_unwritten", 32'(btn_a), 32'd0);
    pulse_start_a(16'h1234, 1'b1, k);
    drain_a(200);
    wait_idle_a(5);
    pulse_start_a(16'h0001, 1'b0, k);
    wait_idle_a(200);
    check("deb_glitch_held", 32'(btn_a), 32'h1234);
    pulse_start_a(16'h0001, 1'b1, k);
    drain_a(200);
    wait_idle_a(5);

    pulse_start_b(8'h81, 1'b0, k);
    repeat (25) @(negedge clk);
    check("deb_b_first", 32'(btn_b), 32'd0);
    pulse_start_b(8'h81, 1'b1, k);
    for (int i = 0; i < 40 && exp_b.size() != 0; i++) @(negedge clk);
    check("drain_b", exp_b.size(), 0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
